// File: rtl/alu_exec.sv
// Execution-stage ALU with a 2-entry result queue behind a valid/ready handshake.
// Results are computed at the accept edge and stored with their zero/illegal flags.
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             alu_zero;

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (alu_ctl)
            CTL_AND: alu_res = src_a & src_b;
            CTL_OR:  alu_res = src_a | src_b;
            CTL_ADD: alu_res = src_a + src_b;
            CTL_SUB: alu_res = src_a - src_b;
            CTL_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_ill = 1'b1;
        endcase
    end

    assign alu_zero = (alu_res == '0);

    logic [WIDTH-1:0] q_result [2];
    logic [1:0]       q_zero;
    logic [1:0]       q_illegal;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    // in_ready comes only from registered occupancy, never from out_ready.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_result[0] <= '0;
            q_result[1] <= '0;
            q_zero      <= '0;
            q_illegal   <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                q_result[wr_ptr]  <= alu_res;
                q_zero[wr_ptr]    <= alu_zero;
                q_illegal[wr_ptr] <= alu_ill;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign result  = out_valid ? q_result[rd_ptr]  : '0;
    assign zero    = out_valid ? q_zero[rd_ptr]    : 1'b0;
    assign illegal = out_valid ? q_illegal[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec: reset, arithmetic, illegal codes,
// streaming with simultaneous push/pop, backpressure and mid-stream reset.
module tb_alu_exec;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    int n_chk;
    int n_pass;

    alu_exec #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctl   (alu_ctl),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        alu_ctl  = ctl;
        src_a    = a;
        src_b    = b;
    endtask

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ill;
        string       tag;
    } vec_t;

    vec_t vecs [10];

    initial begin
        n_chk  = 0;
        n_pass = 0;
        vecs[0] = '{4'b0010, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0, "add_wrap"};
        vecs[1] = '{4'b0110, 32'h3,         32'h5,         32'hFFFF_FFFE, 1'b0, 1'b0, "sub_neg"};
        vecs[2] = '{4'b0111, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0, "slt_m1_1"};
        vecs[3] = '{4'b0111, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, "slt_1_m1"};
        vecs[4] = '{4'b0000, 32'hF0F0,      32'hFF00,      32'hF000,      1'b0, 1'b0, "and"};
        vecs[5] = '{4'b0001, 32'h0F,        32'hF0,        32'hFF,        1'b0, 1'b0, "or"};
        vecs[6] = '{4'b1111, 32'h1234,      32'h5678,      32'h0,         1'b1, 1'b1, "illegal_f"};
        vecs[7] = '{4'b0010, 32'h5,         32'h7,         32'hC,         1'b0, 1'b0, "add_after_ill"};
        vecs[8] = '{4'b0011, 32'hDEAD,      32'hBEEF,      32'h0,         1'b1, 1'b1, "illegal_3"};
        vecs[9] = '{4'b0110, 32'hA,         32'hA,         32'h0,         1'b1, 1'b0, "sub_eq"};

        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 4'b0, 32'h0, 32'h0);
        step();
        step();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_result",    result,             32'd0);
        check("rst_zero",      {31'b0, zero},      32'd0);
        check("rst_illegal",   {31'b0, illegal},   32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Streaming: each op is accepted while the previous head pops on the same edge.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].ctl, vecs[i].a, vecs[i].b);
            check({vecs[i].tag, "_in_ready_pre"}, {31'b0, in_ready}, 32'd1);
            step();
            check({vecs[i].tag, "_valid"},   {31'b0, out_valid},    32'd1);
            check({vecs[i].tag, "_result"},  result,                vecs[i].res);
            check({vecs[i].tag, "_zero"},    {31'b0, zero},         {31'b0, vecs[i].z});
            check({vecs[i].tag, "_illegal"}, {31'b0, illegal},      {31'b0, vecs[i].ill});
            check({vecs[i].tag, "_in_ready"}, {31'b0, in_ready},    32'd1);
        end
        drive(1'b0, 4'b0, 32'h0, 32'h0);
        step();
        check("stream_drained", {31'b0, out_valid}, 32'd0);

        // Backpressure: third ADD must wait until the queue has room.
        out_ready = 1'b0;
        drive(1'b1, 4'b0010, 32'd1, 32'd1);
        step();
        check("bp_first_valid",  {31'b0, out_valid}, 32'd1);
        check("bp_first_result", result,             32'd2);
        check("bp_first_ready",  {31'b0, in_ready},  32'd1);
        drive(1'b1, 4'b0010, 32'd2, 32'd2);
        step();
        check("bp_full_ready",   {31'b0, in_ready},  32'd0);
        check("bp_hold_result1", result,             32'd2);
        drive(1'b1, 4'b0010, 32'd3, 32'd3);
        step();
        check("bp_third_blocked", {31'b0, in_ready}, 32'd0);
        check("bp_hold_result2",  result,            32'd2);
        out_ready = 1'b1;
        step();
        check("bp_pop2_result",  result,             32'd4);
        check("bp_pop2_ready",   {31'b0, in_ready},  32'd1);
        step();
        check("bp_third_result", result,             32'd6);
        check("bp_third_valid",  {31'b0, out_valid}, 32'd1);
        drive(1'b0, 4'b0, 32'h0, 32'h0);
        step();
        check("bp_drained", {31'b0, out_valid}, 32'd0);

        // Reset with two entries pending clears the queue asynchronously.
        out_ready = 1'b0;
        drive(1'b1, 4'b0010, 32'd9, 32'd9);
        step();
        drive(1'b1, 4'b0010, 32'd8, 32'd8);
        step();
        check("pre_rst_full", {31'b0, in_ready}, 32'd0);
        drive(1'b0, 4'b0, 32'h0, 32'h0);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_valid", {31'b0, out_valid}, 32'd0);
        check("async_rst_ready", {31'b0, in_ready},  32'd1);
        check("async_rst_result", result,            32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_empty", {31'b0, out_valid}, 32'd0);
        drive(1'b1, 4'b0010, 32'd5, 32'd7);
        step();
        drive(1'b0, 4'b0, 32'h0, 32'h0);
        check("post_rst_valid",  {31'b0, out_valid}, 32'd1);
        check("post_rst_result", result,             32'd12);
        check("post_rst_zero",   {31'b0, zero},      32'd0);
        step();
        check("post_rst_only_one", result,           32'd12);
        check("post_rst_ready",  {31'b0, in_ready},  32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
